leaf_multi_arbiter: RTL and testbench

- Parametrised multi-channel leaf interface that concentrates NUM_CH child leaf pages onto one BFT leaf port.
- Upstream: per-channel packet FIFOs feed a round-robin arbiter into a single registered output; BFT resend back-pressures the arbiter.
- Downstream: BFT packets are demultiplexed to children by the dst_port field.
- Sits between a BFT leaf switch and the leaf pages instantiated inside a nested DFX region.

---
 rtl/leaf_pkg.sv | 34 +++
 rtl/leaf_pkt_fifo.sv | 80 ++++++++
 rtl/leaf_multi_arbiter.sv | 160 ++++++++++++++++
 tb/tb_leaf_multi_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_pkg.sv
// Purpose : shared packet layout, field positions and arbiter state type for the leaf multi-channel interface.
// Latency : n/a (types, constants and a helper function only).
// Backpressure: n/a.
package leaf_pkg;

    localparam int PKT_W        = 49;
    localparam int VALID_BIT    = 48;
    localparam int DST_LEAF_LSB = 43;
    localparam int DST_LEAF_W   = 5;
    localparam int DST_PORT_LSB = 39;
    localparam int DST_PORT_W   = 4;
    localparam int SRC_LSB      = 32;
    localparam int SRC_W        = 7;
    localparam int PAYLOAD_W    = 32;

    // Field order matches the bit positions above, MSB first.
    typedef struct packed {
        logic                  valid;
        logic [DST_LEAF_W-1:0] dst_leaf;
        logic [DST_PORT_W-1:0] dst_port;
        logic [SRC_W-1:0]      src;
        logic [PAYLOAD_W-1:0]  payload;
    } pkt_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_SEND = 1'b1
    } arb_state_e;

    function automatic logic [DST_PORT_W-1:0] get_port(input logic [PKT_W-1:0] pkt);
        return pkt[DST_PORT_LSB +: DST_PORT_W];
    endfunction

endpackage

// File: rtl/leaf_pkt_fifo.sv
// Purpose : synchronous packet FIFO with occupancy count and registered almost-full flag.
// Latency : a pushed word is visible at pop_dat_o the cycle after the push.
// Backpressure: afull_o is high while occupancy >= DEPTH-1; pushes into a full FIFO are discarded.
//
// Ports: clk/reset (async active-high), push_i/push_dat_i write side,
//        pop_i/pop_dat_o read side (head is combinational), count_o occupancy, afull_o.
module leaf_pkt_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic [CW-1:0]    count_o,
    output logic             afull_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             afull_q;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            // Flag on the post-update count so a writer reacting one cycle late still has a free slot.
            afull_q <= (count_d >= CW'(DEPTH - 1));
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign afull_o   = afull_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push_i && full));

endmodule

// File: rtl/leaf_multi_arbiter.sv
// Purpose : concentrates NUM_CH child leaf ports onto one BFT leaf port and demuxes BFT traffic back by dst_port.
// Latency : upstream 2 cycles (FIFO write, arbiter pop) uncontended; downstream 1 cycle.
// Backpressure: resend holds dout and stalls pops; ch_resend per child when its FIFO nears full; downstream has none.
//
// Ports: clk, reset (async active-high), ap_start -> ch_ap_start (1-cycle copy),
//        din_leaf_bft2interface -> ch_dout (demux), ch_din -> dout_leaf_interface2bft (arbiter),
//        resend / ch_resend flow control, drop_cnt saturating count of packets to nonexistent ports.
module leaf_multi_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int PKT_W      = leaf_pkg::PKT_W,
    parameter int PORT_LSB   = leaf_pkg::DST_PORT_LSB,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ap_start,
    input  logic [PKT_W-1:0]        din_leaf_bft2interface,
    output logic [PKT_W-1:0]        dout_leaf_interface2bft,
    input  logic                    resend,
    input  logic [NUM_CH*PKT_W-1:0] ch_din,
    output logic [NUM_CH*PKT_W-1:0] ch_dout,
    output logic [NUM_CH-1:0]       ch_resend,
    output logic [NUM_CH-1:0]       ch_ap_start,
    output logic [15:0]             drop_cnt
);
    import leaf_pkg::*;

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [PKT_W-1:0]  fifo_head [NUM_CH];
    logic [CNT_W-1:0]  fifo_cnt  [NUM_CH];
    logic [NUM_CH-1:0] fifo_push;
    logic [NUM_CH-1:0] fifo_pop;
    logic [NUM_CH-1:0] fifo_req;

    arb_state_e        state_q;
    logic [PKT_W-1:0]  dout_q;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   rr_next;
    logic              gnt_found;
    logic              pop_en;

    logic [PKT_W-1:0]  ch_dout_q [NUM_CH];
    logic [NUM_CH-1:0] ch_ap_start_q;
    logic [15:0]       drop_cnt_q;

    // ---------------- upstream FIFOs ----------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign fifo_push[i] = ch_din[i*PKT_W + PKT_W - 1] && !ch_resend[i];
        assign fifo_req[i]  = (fifo_cnt[i] != '0);
        assign fifo_pop[i]  = pop_en && (gnt_idx == CH_W'(i));

        leaf_pkt_fifo #(
            .WIDTH (PKT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .push_i     (fifo_push[i]),
            .push_dat_i (ch_din[i*PKT_W +: PKT_W]),
            .pop_i      (fifo_pop[i]),
            .pop_dat_o  (fifo_head[i]),
            .count_o    (fifo_cnt[i]),
            .afull_o    (ch_resend[i])
        );

        assign ch_dout[i*PKT_W +: PKT_W] = ch_dout_q[i];
    end

    // ---------------- round-robin pick ----------------
    // Scan offsets from the far end down so the smallest offset from rr_ptr wins.
    always_comb begin
        logic [CH_W:0] sum;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        sum       = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
            if (sum >= (CH_W+1)'(NUM_CH)) begin
                sum = sum - (CH_W+1)'(NUM_CH);
            end
            if (fifo_req[sum[CH_W-1:0]]) begin
                gnt_idx   = sum[CH_W-1:0];
                gnt_found = 1'b1;
            end
        end
    end

    assign rr_next = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    // An empty output register may always be loaded; a full one only when the BFT took it.
    assign pop_en  = gnt_found && ((state_q == ARB_IDLE) || !resend);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            dout_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pop_en) begin
                        dout_q   <= fifo_head[gnt_idx];
                        rr_ptr_q <= rr_next;
                        state_q  <= ARB_SEND;
                    end
                end
                ARB_SEND: begin
                    if (!resend) begin
                        if (pop_en) begin
                            dout_q   <= fifo_head[gnt_idx];
                            rr_ptr_q <= rr_next;
                        end else begin
                            dout_q  <= '0;
                            state_q <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign dout_leaf_interface2bft = dout_q;

    // ---------------- downstream demux ----------------
    logic [DST_PORT_W-1:0] din_port;
    logic                  din_vld;
    logic                  din_port_ok;

    assign din_port    = din_leaf_bft2interface[PORT_LSB +: DST_PORT_W];
    assign din_vld     = din_leaf_bft2interface[PKT_W-1];
    assign din_port_ok = ({1'b0, din_port} < (DST_PORT_W+1)'(NUM_CH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_dout_q[i] <= '0;
            end
            ch_ap_start_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_dout_q[i] <= (din_vld && din_port_ok && (din_port == DST_PORT_W'(i)))
                                ? din_leaf_bft2interface : '0;
            end
            ch_ap_start_q <= {NUM_CH{ap_start}};
            if (din_vld && !din_port_ok && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign ch_ap_start = ch_ap_start_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_leaf_multi_arbiter.sv
// Purpose : directed self-checking bench for leaf_multi_arbiter (NUM_CH=4, 49-bit packets).
// Latency : inputs driven 1ns after a rising edge, outputs checked 1ns after the next one.
// Backpressure: child models only present words while their ch_resend is low.
`timescale 1ns/1ps
module tb_leaf_multi_arbiter;
    import leaf_pkg::*;

    localparam int NCH = 4;
    localparam int W   = 49;

    typedef logic [W-1:0] word_q_t [$];

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ap_start = 1'b0;
    logic             resend = 1'b0;
    logic [W-1:0]     din = '0;
    logic [W-1:0]     dout;
    logic [W-1:0]     ch_in [NCH];
    logic [NCH*W-1:0] ch_din;
    logic [NCH*W-1:0] ch_dout;
    logic [NCH-1:0]   ch_resend;
    logic [NCH-1:0]   ch_ap_start;
    logic [15:0]      drop_cnt;

    int      n_vec = 0;
    int      n_err = 0;
    word_q_t sb [NCH];
    int      seq [NCH];
    int      exp_ch;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCH; g++) begin : g_in
        assign ch_din[g*W +: W] = ch_in[g];
    end

    leaf_multi_arbiter #(
        .NUM_CH     (NCH),
        .PKT_W      (W),
        .PORT_LSB   (39),
        .FIFO_DEPTH (4)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .ap_start                (ap_start),
        .din_leaf_bft2interface  (din),
        .dout_leaf_interface2bft (dout),
        .resend                  (resend),
        .ch_din                  (ch_din),
        .ch_dout                 (ch_dout),
        .ch_resend               (ch_resend),
        .ch_ap_start             (ch_ap_start),
        .drop_cnt                (drop_cnt)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int src, input int port, input logic [31:0] pl);
        pkt_t p;
        p.valid    = 1'b1;
        p.dst_leaf = 5'd0;
        p.dst_port = 4'(port);
        p.src      = 7'(src);
        p.payload  = pl;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        resend = 1'b0;
        din    = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_in[i] = '0;
            sb[i].delete();
            seq[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Children present a fresh word only when their back-pressure is low; each such word is taken at the next edge.
    task automatic drive_children(input logic [NCH-1:0] en);
        logic [W-1:0] w;
        for (int i = 0; i < NCH; i++) begin
            if (en[i] && !ch_resend[i]) begin
                w = mk(i, 0, {16'(i), 16'(seq[i])});
                seq[i]++;
                ch_in[i] = w;
                sb[i].push_back(w);
            end else begin
                ch_in[i] = '0;
            end
        end
    endtask

    // The word currently on dout is consumed at the coming edge when resend is low.
    task automatic consume();
        int ch;
        if (dout[W-1] && !resend) begin
            ch = int'(dout[38:32]);
            if (ch < NCH && sb[ch].size() > 0) begin
                void'(sb[ch].pop_front());
            end
        end
    endtask

    task automatic observe(input bit check_rr);
        int ch;
        if (dout[W-1]) begin
            ch = int'(dout[38:32]);
            if (ch >= NCH || sb[ch].size() == 0) begin
                chk("sb_unexpected", dout, '0);
            end else begin
                chk("sb_word", dout, sb[ch][0]);
            end
            if (check_rr) begin
                chk("rr_order", ch, exp_ch);
                exp_ch = (exp_ch + 1) % NCH;
            end
        end
    endtask

    task automatic cycle(input logic [NCH-1:0] en, input logic rs, input bit check_rr);
        drive_children(en);
        resend = rs;
        consume();
        tick();
        observe(check_rr);
    endtask

    initial begin
        logic [W-1:0]     w;
        logic [W-1:0]     w_b;
        logic [NCH*W-1:0] e;
        int               nvalid;

        for (int i = 0; i < NCH; i++) ch_in[i] = '0;

        // ---- reset state ----
        #12;
        chk("rst_dout", dout, '0);
        chk("rst_ch_dout", ch_dout, '0);
        chk("rst_ch_resend", ch_resend, '0);
        chk("rst_drop", drop_cnt, '0);
        do_reset();
        tick();
        chk("idle_dout", dout, '0);
        chk("idle_ap", ch_ap_start, '0);
        ap_start = 1'b1;
        tick();
        chk("ap_pulse", ch_ap_start, 4'hF);
        ap_start = 1'b0;
        tick();
        chk("ap_clear", ch_ap_start, 4'h0);

        // ---- single channel latency ----
        w = mk(2, 0, 32'hA5A5_0001);
        ch_in[2] = w;
        tick();
        ch_in[2] = '0;
        chk("single_t1", dout, '0);
        tick();
        chk("single_t2", dout, w);
        tick();
        chk("single_t3", dout, '0);

        // ---- fairness: all channels streaming ----
        do_reset();
        exp_ch = 0;
        nvalid = 0;
        for (int c = 0; c < 30; c++) begin
            cycle(4'hF, 1'b0, 1'b1);
            if (dout[W-1]) nvalid++;
        end
        chk("fair_rate", nvalid, 29);
        for (int c = 0; c < 20; c++) cycle(4'h0, 1'b0, 1'b0);
        for (int i = 0; i < NCH; i++) chk("fair_drained", sb[i].size(), 0);
        chk("fair_idle", dout, '0);

        // ---- back-pressure ----
        do_reset();
        cycle(4'b0001, 1'b1, 1'b0);
        w = sb[0][0];
        cycle(4'b0001, 1'b1, 1'b0);
        cycle(4'b0001, 1'b1, 1'b0);
        chk("bp_resend_low", ch_resend, 4'b0000);
        cycle(4'b0001, 1'b1, 1'b0);
        chk("bp_resend_high", ch_resend, 4'b0001);
        for (int c = 4; c < 20; c++) cycle(4'b0001, 1'b1, 1'b0);
        chk("bp_hold", dout, w);
        chk("bp_accepted", sb[0].size(), 4);
        for (int c = 0; c < 10; c++) cycle(4'b0001, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) cycle(4'b0000, 1'b0, 1'b0);
        chk("bp_drained", sb[0].size(), 0);
        chk("bp_idle", dout, '0);

        // ---- downstream demux ----
        din = mk(5, 1, 32'h1111_2222);
        e = '0;
        e[1*W +: W] = din;
        tick();
        chk("dmx_port1", ch_dout, e);
        din = '0;
        tick();
        chk("dmx_idle", ch_dout, '0);
        din = mk(5, 7, 32'h3333_4444);
        tick();
        chk("dmx_p7_out", ch_dout, '0);
        chk("dmx_p7_drop", drop_cnt, 16'd1);
        din = mk(6, 3, 32'h5555_6666);
        e = '0;
        e[3*W +: W] = din;
        tick();
        chk("dmx_port3", ch_dout, e);
        chk("dmx_p3_nodrop", drop_cnt, 16'd1);
        din = mk(6, 4, 32'h7777_8888);
        tick();
        chk("dmx_p4_out", ch_dout, '0);
        chk("dmx_p4_drop", drop_cnt, 16'd2);
        din = '0;
        tick();

        // ---- reset mid-operation ----
        do_reset();
        for (int c = 0; c < 3; c++) cycle(4'hF, 1'b1, 1'b0);
        chk("mid_busy", dout[W-1], 1'b1);
        for (int i = 0; i < NCH; i++) ch_in[i] = '0;
        #3 reset = 1'b1;
        #1;
        chk("mid_async_dout", dout, '0);
        chk("mid_async_resend", ch_resend, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        resend = 1'b0;
        w   = mk(0, 0, 32'hC0DE_0000);
        w_b = mk(3, 0, 32'hC0DE_0003);
        ch_in[0] = w;
        ch_in[3] = w_b;
        tick();
        ch_in[0] = '0;
        ch_in[3] = '0;
        tick();
        chk("mid_first_ch0", dout, w);
        tick();
        chk("mid_second_ch3", dout, w_b);
        tick();
        chk("mid_empty", dout, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
